// File: rtl/pipelined_divider_unit_if.sv
// Handshake and operand/result bundle for pipelined_divider_unit.
// The divider takes the slave side; the producer/consumer takes master.
interface pipelined_divider_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pipelined_divider_unit.sv
// Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, one operation in flight.
module pipelined_divider_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pipelined_divider_unit_if.slave bus
);
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   sh_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   quo_o;
  logic [WIDTH-1:0] rem_o;
  logic            dbz_o;

  logic [WIDTH:0]  shifted;
  logic [WIDTH:0]  diff;
  logic            ge;
  logic [WIDTH-1:0] rem_n;
  logic [DW-1:0]   sh_n;
  logic            last_step;
  logic            in_ready_c, out_valid_c;

  // Dividend bits leave sh_q at the MSB while quotient bits enter at the LSB,
  // so after DW steps sh_q holds the complete quotient.
  always_comb begin
    shifted   = {rem_q, sh_q[DW-1]};
    diff      = shifted - {1'b0, div_q};
    ge        = (shifted >= {1'b0, div_q});
    rem_n     = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    sh_n      = {sh_q[DW-2:0], ge};
    last_step = (cnt_q == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = (bus.divisor == '0) ? DONE : BUSY;
      BUSY: if (last_step)    state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state == IDLE);
    out_valid_c = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      div_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      quo_o <= '0;
      rem_o <= '0;
      dbz_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sh_q  <= bus.dividend;
          div_q <= bus.divisor;
          rem_q <= '0;
          cnt_q <= '0;
          if (bus.divisor == '0) begin
            quo_o <= '1;
            rem_o <= '0;
            dbz_o <= 1'b1;
          end
        end
        BUSY: begin
          sh_q  <= sh_n;
          rem_q <= rem_n;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            quo_o <= sh_n;
            rem_o <= rem_n;
            dbz_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.quotient    = quo_o;
  assign bus.remainder   = rem_o;
  assign bus.div_by_zero = dbz_o;
endmodule

// File: tb/tb_pipelined_divider_unit.sv
// Directed checks of pipelined_divider_unit: arithmetic, latency,
// divide-by-zero, backpressure, input isolation and mid-operation reset.
module tb_pipelined_divider_unit;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipelined_divider_unit_if #(.WIDTH(WIDTH)) bus ();

  pipelined_divider_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for the result with a cycle budget and check it.
  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [15:0] exp_q, input logic [7:0] exp_r,
                        input logic exp_dbz, input int unsigned exp_lat);
    int unsigned lat;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(bus.quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(bus.remainder), 32'(exp_r));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    bus.out_ready = 1'b1;
    tick();
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int unsigned lat;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst quotient", 32'(bus.quotient), 32'd0);
    check("rst remainder", 32'(bus.remainder), 32'd0);
    check("rst div_by_zero", 32'(bus.div_by_zero), 32'd0);

    run_op("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
    run_op("65025/255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 16);
    run_op("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16);
    run_op("5/9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16);
    run_op("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 0);
    run_op("12345/100", 16'd12345, 8'd100, 16'd123, 8'd45, 1'b0, 16);
    run_op("60000/200", 16'd60000, 8'd200, 16'd300, 8'd0, 1'b0, 16);

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.dividend  = 16'd12345;
    bus.divisor   = 8'd100;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp latency", 32'(lat), 32'd16);
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp quotient", 32'(bus.quotient), 32'd123);
      check("bp remainder", 32'(bus.remainder), 32'd45);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp out_valid drop", 32'(bus.out_valid), 32'd0);
    check("bp in_ready back", 32'(bus.in_ready), 32'd1);
    check("bp quotient kept", 32'(bus.quotient), 32'd123);

    // Operands wiggle with in_valid held high while busy; the latched pair wins.
    bus.in_valid = 1'b1;
    bus.dividend = 16'd5000;
    bus.divisor  = 8'd13;
    tick();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.dividend = 16'(lat * 977 + 3);
      bus.divisor  = 8'(lat + 1);
      check("ign in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check("ign latency", 32'(lat), 32'd16);
    check("ign quotient", 32'(bus.quotient), 32'd384);
    check("ign remainder", 32'(bus.remainder), 32'd8);
    tick();
    check("ign in_ready back", 32'(bus.in_ready), 32'd1);

    // Reset part-way through 1000/7 must discard the operation.
    bus.in_valid = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst quotient", 32'(bus.quotient), 32'd0);
    check("mrst remainder", 32'(bus.remainder), 32'd0);
    tick();
    check("mrst no result", 32'(bus.out_valid), 32'd0);
    run_op("100/3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
